// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of an asynchronous FIFO among NUM_REQ
// requesters in the write-clock domain. Requesters get the port round-robin,
// in bursts of up to MAX_BURST beats. Every beat is gated on wr_full, so the
// FIFO cannot overflow. A saturating counter records the accepted beats.
//
// Ports
//   wr_clk      in   FIFO write-domain clock; all logic is rising-edge
//   reset       in   synchronous active-low reset
//   req_en      in   [NUM_REQ]        per-requester enable; 0 = never granted
//   req_valid   in   [NUM_REQ]        requester i presents a beat
//   req_data    in   [NUM_REQ*WIDTH]  slice i = bits [i*WIDTH +: WIDTH]
//   req_ready   out  [NUM_REQ]        beat i accepted when valid & ready
//   wr_full     in   FIFO full flag
//   fifo_wr_en  out  write strobe to the FIFO
//   fifo_data   out  [WIDTH]          data to the FIFO
//   grant       out  [NUM_REQ]        one-hot owner; zero when there is no owner
//   busy        out  high while an owner holds the port
//   wr_count    out  [16]             accepted-beat count, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       wr_clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       wr_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [15:0]                wr_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_e;

    state_e           state_q,      state_d;
    logic [IDX_W-1:0] owner_q,      owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
    logic [15:0]      wr_count_q,   wr_count_d;

    // ------------------------------------------------------------------
    // Round-robin pick: the first candidate after last_owner, wrapping.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] cand;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     scan_idx;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        cand       = req_valid & req_en;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // last_owner + 1 + i stays below 2*NUM_REQ, so one subtraction wraps it.
            scan_idx = {1'b0, last_owner_q} + (IDX_W+1)'(i + 1);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_found && cand[scan_idx[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner-side datapath. It is combinational from the registered owner,
    // so the strobe follows wr_full with no added latency.
    // ------------------------------------------------------------------
    logic               in_own;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               own_valid;
    logic               own_en;
    logic               own_ready;
    logic               accept;

    assign in_own       = (state_q == ST_OWN);
    assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign own_valid    = req_valid[owner_q];
    assign own_en       = req_en[owner_q];
    // An asserted reset withdraws ready at once, so no beat is taken on the
    // edge that clears ownership.
    assign own_ready    = in_own & own_en & ~wr_full & reset;
    assign accept       = own_ready & own_valid;

    assign grant      = in_own ? owner_onehot : '0;
    assign busy       = in_own;
    assign req_ready  = own_ready ? owner_onehot : '0;
    assign fifo_wr_en = accept;
    assign fifo_data  = in_own ? req_data[owner_q*WIDTH +: WIDTH] : '0;
    assign wr_count   = wr_count_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        wr_count_d   = wr_count_q;

        case (state_q)
            ST_IDLE: begin
                // Arbitration bubble: no beat is accepted in this state.
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_OWN;
                end
            end

            ST_OWN: begin
                if (accept) begin
                    if (wr_count_q != 16'hFFFF) begin
                        wr_count_d = wr_count_q + 16'd1;
                    end
                    if (beat_cnt_q == BEAT_LAST) begin
                        last_owner_d = owner_q;
                        state_d      = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else if (!own_valid || !own_en) begin
                    // The owner stopped early, so its burst is truncated.
                    last_owner_d = owner_q;
                    state_d      = ST_IDLE;
                end
                // valid, enabled and full: hold. A full FIFO never forces
                // the port to rotate.
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            beat_cnt_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_count_q   <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter with the default parameters (WIDTH=8,
// NUM_REQ=4, MAX_BURST=4). Requester i presents an incrementing data stream
// that starts at 8'hA0 + 16*i. The stream advances only when the handshake
// completes. Inputs change 1 time unit after the rising edge, and outputs are
// sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic        wr_clk;
    logic        reset;
    logic [3:0]  req_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wr_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] wr_count;

    logic [7:0]  next_data [4];
    logic [17:0] obs;
    int          checks;
    int          errors;

    fifo_wr_arbiter #(
        .WIDTH    (8),
        .NUM_REQ  (4),
        .MAX_BURST(4)
    ) dut (
        .wr_clk    (wr_clk),
        .reset     (reset),
        .req_en    (req_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_full   (wr_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data (fifo_data),
        .grant     (grant),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    assign obs = {grant, req_ready, fifo_wr_en, busy, fifo_data};

    // Packs an expected output vector. busy is high exactly when grant is set.
    function automatic logic [17:0] mk(input logic [3:0] g, input logic [3:0] r,
                                       input logic we, input logic [7:0] d);
        return {g, r, we, |g, d};
    endfunction

    task automatic pack_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = next_data[i];
    endtask

    // Advance one cycle. A requester's stream moves on only if its beat was
    // handshaken before the edge.
    task automatic step();
        logic [3:0] acc;
        acc = req_valid & req_ready;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) next_data[i] = next_data[i] + 8'd1;
        pack_data();
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_en    = 4'b1111;
        wr_full   = 1'b0;
        for (int i = 0; i < 4; i++) next_data[i] = 8'hA0 + 8'(16 * i);
        pack_data();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_en    = 4'b1111;
        req_valid = 4'b1111;
        wr_full   = 1'b0;
        for (int i = 0; i < 4; i++) next_data[i] = 8'hA0 + 8'(16 * i);
        pack_data();
        step();
        step();
        #1;
        if (obs !== mk(4'b0000, 4'b0000, 1'b0, 8'h00)) begin
            $display("FAIL reset_outputs: got %h want %h", obs, mk(4'b0000, 4'b0000, 1'b0, 8'h00));
            errors++;
        end
        checks++;
        if (wr_count !== 16'd0) begin
            $display("FAIL reset_wr_count: got %0d want 0", wr_count);
            errors++;
        end
        checks++;
        step();
    endtask

    // Test 1: a single requester streams six beats, split 4 + 2 with a bubble between.
    task automatic test_single_requester();
        logic [17:0] exp;
        apply_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0 || c == 5) exp = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
            else exp = mk(4'b0001, 4'b0001, 1'b1, 8'hA0 + 8'((c < 5) ? c - 1 : c - 2));
            if (obs !== exp) begin
                $display("FAIL single c%0d: got %h want %h", c, obs, exp);
                errors++;
            end
            checks++;
            step();
        end
        req_valid = 4'b0000;
        #1;
        if (obs !== mk(4'b0001, 4'b0001, 1'b0, 8'hA6)) begin
            $display("FAIL single_release: got %h want %h", obs, mk(4'b0001, 4'b0001, 1'b0, 8'hA6));
            errors++;
        end
        checks++;
        step();
        #1;
        if (obs !== mk(4'b0000, 4'b0000, 1'b0, 8'h00) || wr_count !== 16'd6) begin
            $display("FAIL single_idle: got %h/%0d want %h/6", obs, wr_count, mk(4'b0000, 4'b0000, 1'b0, 8'h00));
            errors++;
        end
        checks++;
    endtask

    // Test 2: all four requesters are valid and rotate 0,1,2,3,0 with 4 beats each.
    task automatic test_round_robin();
        logic [17:0] exp;
        apply_reset();
        req_valid = 4'b1111;
        for (int o = 0; o < 4; o++) begin
            for (int b = 0; b < 5; b++) begin
                #1;
                if (b == 0) exp = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
                else exp = mk(4'(1 << o), 4'(1 << o), 1'b1, 8'hA0 + 8'(16 * o) + 8'(b - 1));
                if (obs !== exp) begin
                    $display("FAIL rr o%0d b%0d: got %h want %h", o, b, obs, exp);
                    errors++;
                end
                checks++;
                step();
            end
        end
        #1;
        if (wr_count !== 16'd16) begin
            $display("FAIL rr_count: got %0d want 16", wr_count);
            errors++;
        end
        checks++;
        step();
        #1;
        if (obs !== mk(4'b0001, 4'b0001, 1'b1, 8'hA4)) begin
            $display("FAIL rr_wrap: got %h want %h", obs, mk(4'b0001, 4'b0001, 1'b1, 8'hA4));
            errors++;
        end
        checks++;
    endtask

    // Test 3: wr_full stalls req1 at beat 2 for five cycles. There is no
    // rotation while the FIFO is full.
    task automatic test_full_stall();
        logic [17:0] exp;
        logic [11:0] full_pat;
        full_pat = 12'b0000_1111_1000;
        apply_reset();
        req_valid = 4'b0110;
        for (int c = 0; c < 12; c++) begin
            wr_full = full_pat[c];
            #1;
            case (c)
                0, 10:   exp = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
                1:       exp = mk(4'b0010, 4'b0010, 1'b1, 8'hB0);
                2:       exp = mk(4'b0010, 4'b0010, 1'b1, 8'hB1);
                8:       exp = mk(4'b0010, 4'b0010, 1'b1, 8'hB2);
                9:       exp = mk(4'b0010, 4'b0010, 1'b1, 8'hB3);
                11:      exp = mk(4'b0100, 4'b0100, 1'b1, 8'hC0);
                default: exp = mk(4'b0010, 4'b0000, 1'b0, 8'hB2);
            endcase
            if (obs !== exp) begin
                $display("FAIL full c%0d: got %h want %h", c, obs, exp);
                errors++;
            end
            checks++;
            if (c == 7 && wr_count !== 16'd2) begin
                $display("FAIL full_count: got %0d want 2", wr_count);
                errors++;
            end
            if (c == 7) checks++;
            step();
        end
        wr_full = 1'b0;
    endtask

    // Test 4: req2 drops valid after one beat. The burst ends and req3 is granted next.
    task automatic test_early_release();
        logic [17:0] exp;
        apply_reset();
        req_valid = 4'b1100;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req_valid = 4'b1000;
            #1;
            case (c)
                0, 3:    exp = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
                1:       exp = mk(4'b0100, 4'b0100, 1'b1, 8'hC0);
                2:       exp = mk(4'b0100, 4'b0100, 1'b0, 8'hC1);
                default: exp = mk(4'b1000, 4'b1000, 1'b1, 8'hD0);
            endcase
            if (obs !== exp) begin
                $display("FAIL early c%0d: got %h want %h", c, obs, exp);
                errors++;
            end
            checks++;
            step();
        end
        #1;
        if (wr_count !== 16'd2) begin
            $display("FAIL early_count: got %0d want 2", wr_count);
            errors++;
        end
        checks++;
    endtask

    // Test 5: requester 2 is disabled and is never granted. The order is 0,1,3,0.
    task automatic test_enable_mask();
        logic [17:0] exp;
        int order [3];
        order = '{0, 1, 3};
        apply_reset();
        req_en    = 4'b1011;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 5; b++) begin
                #1;
                if (b == 0) exp = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
                else exp = mk(4'(1 << order[k]), 4'(1 << order[k]), 1'b1,
                              8'hA0 + 8'(16 * order[k]) + 8'(b - 1));
                if (obs !== exp) begin
                    $display("FAIL mask k%0d b%0d: got %h want %h", k, b, obs, exp);
                    errors++;
                end
                checks++;
                step();
            end
        end
        step();
        #1;
        if (obs !== mk(4'b0001, 4'b0001, 1'b1, 8'hA4)) begin
            $display("FAIL mask_wrap: got %h want %h", obs, mk(4'b0001, 4'b0001, 1'b1, 8'hA4));
            errors++;
        end
        checks++;
        req_en = 4'b1111;
    endtask

    // Test 6: reset in the middle of a req0 burst, with wr_count = 7.
    task automatic test_reset_midburst();
        logic [17:0] exp;
        apply_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c == 0 || c == 5) exp = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
            else exp = mk(4'b0001, 4'b0001, 1'b1, 8'hA0 + 8'((c < 5) ? c - 1 : c - 2));
            if (obs !== exp) begin
                $display("FAIL midrst c%0d: got %h want %h", c, obs, exp);
                errors++;
            end
            checks++;
            step();
        end
        #1;
        if (wr_count !== 16'd7) begin
            $display("FAIL midrst_count7: got %0d want 7", wr_count);
            errors++;
        end
        checks++;
        reset = 1'b0;
        #1;
        if (obs !== mk(4'b0001, 4'b0000, 1'b0, 8'hA7)) begin
            $display("FAIL midrst_gate: got %h want %h", obs, mk(4'b0001, 4'b0000, 1'b0, 8'hA7));
            errors++;
        end
        checks++;
        step();
        #1;
        if (obs !== mk(4'b0000, 4'b0000, 1'b0, 8'h00) || wr_count !== 16'd0) begin
            $display("FAIL midrst_clear: got %h/%0d want %h/0", obs, wr_count, mk(4'b0000, 4'b0000, 1'b0, 8'h00));
            errors++;
        end
        checks++;
        reset = 1'b1;
        step();
        #1;
        if (obs !== mk(4'b0001, 4'b0001, 1'b1, 8'hA7)) begin
            $display("FAIL midrst_regrant: got %h want %h", obs, mk(4'b0001, 4'b0001, 1'b1, 8'hA7));
            errors++;
        end
        checks++;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        req_en    = 4'b0000;
        req_valid = 4'b0000;
        req_data  = '0;
        wr_full   = 1'b0;
        #1;
        test_reset();
        test_single_requester();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_enable_mask();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters in the wr_clk domain. It grants the port round-robin in bursts of up to MAX_BURST beats. It gates every beat on the FIFO's wr_full flag so the FIFO never overflows. It also keeps a saturating count of accepted writes for status readout.

Parameters:
WIDTH, 8, data width; matches the FIFO data_in width
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, maximum beats per grant before forced rotation (1..16)

Ports:
wr_clk  input  1  FIFO write-domain clock; all logic rising-edge
reset  input  1  synchronous, active-low reset (sampled on wr_clk)
req_en  input  NUM_REQ  per-requester enable mask; 0 = never granted
req_valid  input  NUM_REQ  requester i has a beat on req_data slice i
req_data  input  NUM_REQ*WIDTH  flattened data; slice i = bits [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  beat i accepted this cycle when req_valid[i] & req_ready[i]
wr_full  input  1  FIFO full flag, write domain
fifo_wr_en  output  1  write strobe to FIFO
fifo_data  output  WIDTH  data to FIFO data_in
grant  output  NUM_REQ  one-hot current owner; all zero when no owner
busy  output  1  1 while an owner holds the port
wr_count  output  16  accepted-beat counter, saturates at 16'hFFFF

Behaviour:
- Reset (reset==0 at a wr_clk edge):
  - state=IDLE; grant=0; busy=0; req_ready=0; fifo_wr_en=0; fifo_data=0; wr_count=0; beat_cnt=0.
  - last_owner=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-burst drops ownership immediately; no write on that edge.
- State IDLE:
  - Candidates = req_valid & req_en.
  - If any candidate, select the first one searching last_owner+1, +2, ... modulo NUM_REQ.
  - Register the selection as owner, set beat_cnt=0, go to OWN.
  - There is one arbitration bubble cycle; no beat is accepted while in IDLE.
- State OWN:
  - grant=onehot(owner); busy=1.
  - req_ready[owner] = req_en[owner] & ~wr_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[owner] & req_ready[owner]. This is combinational, zero latency, so the strobe is never asserted while wr_full=1.
  - fifo_data = req_data slice[owner], muxed combinationally from the registered owner; 0 when not in OWN.
  - Beat accepted:
    - wr_count increments (saturating).
    - If beat_cnt==MAX_BURST-1, set last_owner=owner and go to IDLE.
    - Otherwise beat_cnt increments.
  - req_valid[owner]==0 or req_en[owner]==0: set last_owner=owner and go to IDLE (early release, burst truncated).
  - req_valid[owner]==1, req_en[owner]==1 and wr_full==1: hold in OWN, beat_cnt unchanged. A full FIFO never forces a rotation.
- Boundaries:
  - The MAX_BURST limit guarantees no starvation: each enabled requester waits at most (NUM_REQ-1)*(MAX_BURST+1) non-full cycles.
  - Only the owner's req_valid affects OWN. Other requesters' valid changes are ignored until IDLE.
  - wr_count holds at 16'hFFFF once saturated; it is cleared only by reset.
  - MAX_BURST=1: every beat is followed by IDLE, so the sustained rate is one beat per 2 cycles.

Test Plan:
1. Reset, then req_valid=4'b0001, data 8'hA0..A5, wr_full=0 -> grant=0001 after 1 bubble; 4 beats A0..A3 written on consecutive cycles; IDLE; re-grant to req0; A4,A5 follow.
2. All four valid continuously, MAX_BURST=4 -> grant sequence 0001,0010,0100,1000,0001; each owner writes exactly 4 beats; wr_count=16 after the 4 grants.
3. req1 owner mid-burst (beat_cnt=2), wr_full=1 for 5 cycles -> fifo_wr_en=0 and req_ready=0 for those 5 cycles; grant stays 0010; remaining 2 beats written after wr_full drops; then rotation.
4. req2 owner drops req_valid after 1 beat while req3 valid -> IDLE next cycle; grant=1000 after the bubble; last_owner=2.
5. req_en=4'b1011 with all valid -> requester 2 never granted; order 0,1,3,0.
6. Assert reset (0) during a burst of req0 with wr_count=7 -> next cycle grant=0, fifo_wr_en=0, wr_count=0; after release, req0 is granted first again.
